led_mode_selector: RTL and testbench
====================================

// Module: led_mode_selector
// PURPOSE
//  Upstream stage for the LED pattern drivers (mode-3 heartbeat driver and siblings).
//  Debounces the user key and steps through N_MODES patterns.
//  Holds the selected driver in restart during a short blanking gap on every change.
//  Muxes the selected driver's 8-bit LED vector to the board pins.
// PARAMETERS
//  N_MODES      4        number of pattern drivers (>=2); MW = clog2(N_MODES)
//  DEB_CYCLES   240000   consecutive stable cycles to accept a key level (20 ms @12 MHz)
//  LONG_CYCLES  24000000 key-held cycles for long press (2 s @12 MHz)
//  BLANK_CYCLES 1200     blanking length on mode change (100 us @12 MHz)
// PORTS
//  clk       in   1          12 MHz system clock
//  rst       in   1          asynchronous reset, active-high
//  key_n     in   1          raw push-button, active-low, asynchronous, bouncy
//  led_in    in   8*N_MODES  driver outputs; slice [8*i+7:8*i] = mode i
//  led_out   out  8          registered LED drive to pins
//  mode      out  MW         current mode index
//  mode_chg  out  1          1-cycle pulse on the edge mode updates
//  drv_rst   out  1          active-high restart to all pattern drivers
// BEHAVIOUR
//  Reset (async): sync FFs=1, key_stable=1, deb_cnt=0, hold_cnt=0, mode=0, state=BLANK,
//   blank_cnt=0, led_out=0, drv_rst=1, mode_chg=0, long_done=0.
//  Sync: 2-FF synchroniser on key_n -> key_sync.
//  Debounce: key_sync!=key_stable -> deb_cnt++; else deb_cnt=0.
//   At deb_cnt==DEB_CYCLES-1 with still differing: key_stable<=key_sync, deb_cnt<=0.
//   Any bounce inside the window restarts the count.
//  hold_cnt counts cycles with key_stable==0; clears when key_stable==1; saturates at LONG_CYCLES.
//  Long press: hold_cnt reaches LONG_CYCLES-1 -> event GOTO0; set long_done.
//   Fires once per press.
//  Release (key_stable 0->1):
//   long_done=0 -> event NEXT.
//   long_done=1 -> no event; clear long_done.
//  NEXT: mode <= (mode==N_MODES-1) ? 0 : mode+1 (wrap).
//  GOTO0: mode <= 0; issued even if mode is already 0, so the pattern restarts.
//  Events act on the edge after the key_stable transition / hold threshold.
//  Events in BLANK are dropped: mode unchanged, no pulse.
//  FSM:
//   RUN --event--> BLANK, on the same edge: mode updates, mode_chg=1, led_out<=0,
//     drv_rst<=1, blank_cnt<=0.
//   BLANK: blank_cnt++ each cycle; led_out=0, drv_rst=1.
//     At blank_cnt==BLANK_CYCLES-1 -> RUN.
//   RUN: drv_rst=0; led_out <= led_in slice[mode] (1-cycle latency).
//  LED/restart timing:
//   led_out is 0 for BLANK_CYCLES+1 cycles after mode_chg.
//   drv_rst is high for exactly BLANK_CYCLES cycles.
//   After reset release, BLANK runs BLANK_CYCLES cycles, then RUN with mode 0.
//  Reset mid-press or mid-blank: immediate return to reset values.
//   A key still held after reset must be released and re-pressed (debounced) to act.
//  mode_chg never asserts in BLANK or during reset.
// TESTING (DEB_CYCLES=4, LONG_CYCLES=40, BLANK_CYCLES=8, N_MODES=4; led_in = {8'h44,8'h33,8'h22,8'h11})
//  1 Reset release:
//    drv_rst=1 and led_out=0 for 8 cycles, then drv_rst=0; next cycle led_out=8'h11, mode=0.
//  2 Clean press 10 cycles, then release:
//    no event on press; on release mode=1 and one mode_chg pulse.
//    led_out=0 for 9 cycles, then 8'h22.
//  3 Bouncy key (toggle every 2 cycles for 20 cycles, then clean low 10, then high):
//    exactly one NEXT; mode advances by 1.
//  4 Four short presses from mode 3 path (0->1->2->3->0), each spaced > BLANK:
//    mode sequence 1,2,3,0; led_out 22,33,44,11.
//  5 From mode 2, hold 60 cycles:
//    GOTO0 while held; mode=0 with one mode_chg; release yields no further event.
//  6 Press/release completing inside BLANK:
//    dropped (mode unchanged, no mode_chg).
//    Assert rst mid-blank -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/led_mode_selector.sv
// led_mode_selector
// Key debounce, short/long press decode and pattern-driver selection for the
// board LEDs. A short press steps to the next pattern on release. A long press
// jumps to pattern 0 while the key is still held. Every mode change opens a
// blanking gap: the LEDs are dark and the pattern drivers are held in restart,
// so the new pattern always starts from its first step.
//
// state | meaning
// ------+---------------------------------------------------------------
// BLANK | gap after reset or a mode change; led_out=0, drv_rst=1, events dropped
// RUN   | selected driver is live; led_out follows led_in slice[mode]

module led_mode_selector #(
  parameter int N_MODES      = 4,
  parameter int DEB_CYCLES   = 240000,
  parameter int LONG_CYCLES  = 24000000,
  parameter int BLANK_CYCLES = 1200
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_n,
  input  logic [8*N_MODES-1:0]         led_in,
  output logic [7:0]                   led_out,
  output logic [$clog2(N_MODES)-1:0]   mode,
  output logic                         mode_chg,
  output logic                         drv_rst
);

  localparam int MW = $clog2(N_MODES);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int BW = $clog2(BLANK_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_CYCLES);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [MW-1:0] MODE_LAST  = MW'(N_MODES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t          state;
  logic            sync1;
  logic            key_sync;
  logic            key_stable;
  logic            key_stable_d;
  logic [DW-1:0]   deb_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            long_done;
  logic [BW-1:0]   blank_cnt;

  logic            key_rise;
  logic            long_hit;
  logic            ev_next;
  logic            ev_goto0;
  logic            ev_any;
  logic [MW-1:0]   mode_next;

  // Two-flop synchroniser for the asynchronous key; idles high (released).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      sync1    <= key_n;
      key_sync <= sync1;
    end
  end

  // Accept a new key level only after it has differed for DEB_CYCLES in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_stable   <= 1'b1;
      key_stable_d <= 1'b1;
      deb_cnt      <= '0;
    end else begin
      key_stable_d <= key_stable;
      if (key_sync != key_stable) begin
        if (deb_cnt == DEB_LAST) begin
          key_stable <= key_sync;
          deb_cnt    <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Hold timer; saturating so the long-press threshold is crossed only once per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      long_done <= 1'b0;
    end else begin
      if (key_stable) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end

      // long_done suppresses the release event of a press that already jumped to 0
      if (long_hit) begin
        long_done <= 1'b1;
      end else if (key_rise) begin
        long_done <= 1'b0;
      end
    end
  end

  // Press events are decoded from registered state, so they act one edge after
  // the debounced release or the hold threshold.
  assign key_rise  = key_stable & ~key_stable_d;
  assign long_hit  = ~key_stable & (hold_cnt == HOLD_LAST);
  assign ev_next   = key_rise & ~long_done;
  assign ev_goto0  = long_hit;
  assign ev_any    = ev_next | ev_goto0;
  assign mode_next = ev_goto0            ? '0 :
                     (mode == MODE_LAST) ? '0 :
                                           mode + 1'b1;

  // Mode/blanking FSM with registered LED mux and driver restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_BLANK;
      mode      <= '0;
      blank_cnt <= '0;
      led_out   <= '0;
      drv_rst   <= 1'b1;
      mode_chg  <= 1'b0;
    end else begin
      mode_chg <= 1'b0;
      case (state)
        ST_BLANK: begin
          // events arriving here are intentionally discarded
          led_out <= '0;
          if (blank_cnt == BLANK_LAST) begin
            state   <= ST_RUN;
            drv_rst <= 1'b0;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
            drv_rst   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (ev_any) begin
            state     <= ST_BLANK;
            mode      <= mode_next;
            mode_chg  <= 1'b1;
            led_out   <= '0;
            drv_rst   <= 1'b1;
            blank_cnt <= '0;
          end else begin
            led_out <= led_in[8*mode +: 8];
            drv_rst <= 1'b0;
          end
        end
        default: begin
          state     <= ST_BLANK;
          blank_cnt <= '0;
          led_out   <= '0;
          drv_rst   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_mode_selector.sv
// Directed bench for led_mode_selector with short debounce/hold/blank timers.

module tb_led_mode_selector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_n = 1'b1;
  logic [31:0] led_in = {8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0]  led_out;
  logic [1:0]  mode;
  logic        mode_chg;
  logic        drv_rst;

  int n_checks = 0;
  int n_fail   = 0;
  int chg_cnt  = 0;

  led_mode_selector #(
    .N_MODES     (4),
    .DEB_CYCLES  (4),
    .LONG_CYCLES (40),
    .BLANK_CYCLES(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_n   (key_n),
    .led_in  (led_in),
    .led_out (led_out),
    .mode    (mode),
    .mode_chg(mode_chg),
    .drv_rst (drv_rst)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mode_chg) chg_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_chg(input string tag, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (mode_chg) found = 1'b1;
    end
    check({tag, "_chg_seen"}, 32'(found), 32'd1);
  endtask

  // Called on the sample where mode_chg is high; walks the blanking gap.
  task automatic check_blank_seq(input string tag, input logic [1:0] exp_mode,
                                 input logic [7:0] exp_led);
    check({tag, "_mode"}, 32'(mode), 32'(exp_mode));
    for (int k = 0; k < 9; k++) begin
      check({tag, "_led_blank"}, 32'(led_out), 32'd0);
      check({tag, "_drv_rst"}, 32'(drv_rst), (k < 8) ? 32'd1 : 32'd0);
      @(negedge clk);
      if (k == 0) check({tag, "_chg_pulse_width"}, 32'(mode_chg), 32'd0);
    end
    check({tag, "_led"}, 32'(led_out), 32'(exp_led));
    check({tag, "_drv_run"}, 32'(drv_rst), 32'd0);
  endtask

  task automatic short_press(input string tag, input logic [1:0] exp_mode,
                             input logic [7:0] exp_led);
    int c0;
    c0 = chg_cnt;
    key_n = 1'b0;
    wait_cycles(8);
    check({tag, "_no_chg_on_press"}, 32'(chg_cnt - c0), 32'd0);
    key_n = 1'b1;
    wait_chg(tag, 20);
    check_blank_seq(tag, exp_mode, exp_led);
    check({tag, "_one_pulse"}, 32'(chg_cnt - c0), 32'd1);
  endtask

  logic [1:0] seq_mode [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] seq_led  [4] = '{8'h22, 8'h33, 8'h44, 8'h11};

  initial begin
    int c0;
    logic [1:0] seen_mode;

    // reset values while held
    wait_cycles(3);
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_drv", 32'(drv_rst), 32'd1);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_chg", 32'(mode_chg), 32'd0);

    // 1: reset release -> 8 cycles of blanking, then mode 0 pattern
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("t1_drv_blank", 32'(drv_rst), 32'd1);
      check("t1_led_blank", 32'(led_out), 32'd0);
      @(negedge clk);
    end
    check("t1_drv_run", 32'(drv_rst), 32'd0);
    check("t1_led_lat", 32'(led_out), 32'd0);
    @(negedge clk);
    check("t1_led", 32'(led_out), 32'h11);
    check("t1_mode", 32'(mode), 32'd0);
    check("t1_no_chg", 32'(chg_cnt), 32'd0);

    // 2: clean 10-cycle press, event on release
    c0 = chg_cnt;
    key_n = 1'b0;
    wait_cycles(10);
    check("t2_no_chg_on_press", 32'(chg_cnt - c0), 32'd0);
    key_n = 1'b1;
    wait_chg("t2", 20);
    check_blank_seq("t2", 2'd1, 8'h22);
    check("t2_one_pulse", 32'(chg_cnt - c0), 32'd1);

    // 3: bouncy key, one NEXT only
    c0 = chg_cnt;
    for (int i = 0; i < 5; i++) begin
      key_n = 1'b0;
      wait_cycles(2);
      key_n = 1'b1;
      wait_cycles(2);
    end
    key_n = 1'b0;
    wait_cycles(10);
    check("t3_no_chg_bounce", 32'(chg_cnt - c0), 32'd0);
    key_n = 1'b1;
    wait_chg("t3", 20);
    check_blank_seq("t3", 2'd2, 8'h33);
    wait_cycles(10);
    check("t3_one_pulse", 32'(chg_cnt - c0), 32'd1);

    // 4: from a fresh reset, four short presses walk 1,2,3,0
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(12);
    check("t4_start_mode", 32'(mode), 32'd0);
    check("t4_start_led", 32'(led_out), 32'h11);
    for (int i = 0; i < 4; i++) begin
      short_press($sformatf("t4_p%0d", i), seq_mode[i], seq_led[i]);
    end

    // 5: from mode 2, 60-cycle hold jumps to 0 once; release adds nothing
    short_press("t5_a", 2'd1, 8'h22);
    short_press("t5_b", 2'd2, 8'h33);
    c0 = chg_cnt;
    seen_mode = 2'd3;
    key_n = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mode_chg) seen_mode = mode;
    end
    check("t5_long_pulses", 32'(chg_cnt - c0), 32'd1);
    check("t5_long_mode", 32'(seen_mode), 32'd0);
    check("t5_led_held", 32'(led_out), 32'h11);
    check("t5_drv_held", 32'(drv_rst), 32'd0);
    key_n = 1'b1;
    wait_cycles(20);
    check("t5_release_no_event", 32'(chg_cnt - c0), 32'd1);
    check("t5_mode_after", 32'(mode), 32'd0);

    // 6a: second press/release debounced entirely inside the blanking gap is dropped
    c0 = chg_cnt;
    key_n = 1'b0;
    wait_cycles(10);
    key_n = 1'b1;
    wait_cycles(4);
    key_n = 1'b0;
    wait_cycles(4);
    key_n = 1'b1;
    wait_cycles(30);
    check("t6_drop_pulses", 32'(chg_cnt - c0), 32'd1);
    check("t6_drop_mode", 32'(mode), 32'd1);
    check("t6_drop_led", 32'(led_out), 32'h22);

    // 6b: reset asserted mid-blank takes effect immediately
    key_n = 1'b0;
    wait_cycles(8);
    key_n = 1'b1;
    wait_chg("t6_rst", 20);
    check("t6_pre_rst_mode", 32'(mode), 32'd2);
    wait_cycles(2);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_mode", 32'(mode), 32'd0);
    check("t6_rst_led", 32'(led_out), 32'd0);
    check("t6_rst_drv", 32'(drv_rst), 32'd1);
    check("t6_rst_chg", 32'(mode_chg), 32'd0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(12);
    check("t6_after_rst_led", 32'(led_out), 32'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
